// File: rtl/adc_uart_responder_pkg.sv
// Shared protocol definitions for the ADC serial link: channel layout, command base,
// FSM state encodings and response byte packing.
package adc_uart_responder_pkg;

    localparam int              NUM_CH           = 4;
    localparam int              CH_W             = 10;
    localparam logic [7:0]      CMD_BASE_DEFAULT = 8'hA0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // A sample is sent high part first: two MSBs in byte0, low eight bits in byte1.
    function automatic logic [7:0] resp_byte0(input logic [CH_W-1:0] val);
        return {6'b0, val[9:8]};
    endfunction

    function automatic logic [7:0] resp_byte1(input logic [CH_W-1:0] val);
        return val[7:0];
    endfunction

endpackage

// File: rtl/adc_uart_responder_uart_tx_byte.sv
// 8N1 byte transmitter. ready is high while idle and during the final stop-bit clock,
// so a byte loaded then follows the previous one with no idle gap.
module uart_tx_byte
    import adc_uart_responder_pkg::*;
#(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic       clk12MHz,
    input  logic       resetq,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       txd
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign ready = (state == TX_IDLE) || ((state == TX_STOP) && (cnt == '0));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (load) begin
                        state <= TX_START;
                        shreg <= data;
                        cnt   <= BIT_TOP;
                        txd   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (cnt == '0) begin
                        state   <= TX_DATA;
                        cnt     <= BIT_TOP;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == '0) begin
                        cnt <= BIT_TOP;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt == '0) begin
                        if (load) begin
                            state <= TX_START;
                            shreg <= data;
                            cnt   <= BIT_TOP;
                            txd   <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/adc_uart_responder.sv
// Device end of the ADC serial link: decodes 8N1 channel requests and answers each
// valid one with the 10-bit sample as two 8N1 bytes, with a one-deep pending slot.
module adc_uart_responder
    import adc_uart_responder_pkg::*;
#(
    parameter int         CLK_HZ   = 12_000_000,
    parameter int         BAUD     = 250_000,
    parameter logic [7:0] CMD_BASE = CMD_BASE_DEFAULT
) (
    input  logic                   clk12MHz,
    input  logic                   resetq,
    input  logic                   serialIn,
    output logic                   serialOut,
    input  logic [NUM_CH*CH_W-1:0] ch_values,
    output logic                   busy,
    output logic                   cmd_err,
    output logic                   overrun
);

    localparam int               CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_TOP      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_TOP     = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= serialIn;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_idx;
    logic [7:0]       rx_shift;

    // Requiring a high-to-low transition re-arms RX only after a low stop bit clears.
    logic rx_fall, stop_sample, byte_done, frame_err;
    assign rx_fall     = rx_prev & ~rx_sync;
    assign stop_sample = (rx_state == RX_STOP) && (rx_cnt == '0);
    assign byte_done   = stop_sample & rx_sync;
    assign frame_err   = stop_sample & ~rx_sync;

    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_TOP;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state   <= RX_DATA;
                            rx_cnt     <= BIT_TOP;
                            rx_bit_idx <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= BIT_TOP;
                        if (rx_bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [7:0]      cmd_off;
    logic            cmd_known, cmd_ok, bad_cmd;
    logic [CH_W-1:0] snap_val;

    assign cmd_off   = rx_shift - CMD_BASE;
    assign cmd_known = (cmd_off >= 8'd1) && (cmd_off <= 8'(NUM_CH));
    assign cmd_ok    = byte_done & cmd_known;
    assign bad_cmd   = byte_done & ~cmd_known;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        snap_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_off == 8'(i + 1)) snap_val = ch_values[i*CH_W +: CH_W];
        end
    end

    logic            byte_sel;
    logic [CH_W-1:0] cur_val;
    logic            pend_valid;
    logic [CH_W-1:0] pend_val;
    logic            tx_ready, tx_load;
    logic [7:0]      tx_data;
    logic            send_byte1, resp_done, launch_new, launch_pend, to_pend, drop;

    // byte_sel set means byte1 of cur_val is still owed to the transmitter.
    assign send_byte1  = busy && byte_sel && tx_ready;
    assign resp_done   = busy && !byte_sel && tx_ready;
    assign launch_pend = resp_done && pend_valid;
    assign launch_new  = cmd_ok && (!busy || (resp_done && !pend_valid));
    assign to_pend     = cmd_ok && !launch_new && (!pend_valid || launch_pend);
    assign drop        = cmd_ok && !launch_new && !to_pend;

    always_comb begin
        tx_load = send_byte1 | launch_new | launch_pend;
        tx_data = resp_byte0(snap_val);
        if (send_byte1)       tx_data = resp_byte1(cur_val);
        else if (launch_pend) tx_data = resp_byte0(pend_val);
    end

    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            busy       <= 1'b0;
            byte_sel   <= 1'b0;
            cur_val    <= '0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            cmd_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cmd_err <= bad_cmd | frame_err;
            overrun <= drop;

            if (launch_new) begin
                busy     <= 1'b1;
                byte_sel <= 1'b1;
                cur_val  <= snap_val;
            end else if (launch_pend) begin
                byte_sel <= 1'b1;
                cur_val  <= pend_val;
            end else if (send_byte1) begin
                byte_sel <= 1'b0;
            end else if (resp_done) begin
                busy <= 1'b0;
            end

            if (to_pend) begin
                pend_valid <= 1'b1;
                pend_val   <= snap_val;
            end else if (launch_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk12MHz(clk12MHz),
        .resetq  (resetq),
        .load    (tx_load),
        .data    (tx_data),
        .ready   (tx_ready),
        .txd     (serialOut)
    );

endmodule

// File: tb/tb_adc_uart_responder.sv
// Self-checking bench for adc_uart_responder: directed commands, a serial-line monitor
// that decodes serialOut and checks each byte against a scoreboard queue.
`timescale 1ns/1ps
module tb_adc_uart_responder;

    localparam int CPB = 48;

    logic        clk12MHz = 1'b0;
    logic        resetq   = 1'b0;
    logic        serialIn = 1'b1;
    logic [39:0] ch_values = '0;
    logic        serialOut, busy, cmd_err, overrun;

    adc_uart_responder dut (
        .clk12MHz (clk12MHz),
        .resetq   (resetq),
        .serialIn (serialIn),
        .serialOut(serialOut),
        .ch_values(ch_values),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .overrun  (overrun)
    );

    always #42 clk12MHz = ~clk12MHz;

    int cmp_cnt = 0;
    int bad_cnt = 0;
    int cyc = 0;
    int err_pulses = 0, ovr_pulses = 0, busy_cycles = 0, both_pulses = 0;
    int cmd_start_cyc = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk12MHz) cyc <= cyc + 1;

    always @(negedge clk12MHz) begin
        if (resetq) begin
            if (cmd_err) err_pulses++;
            if (overrun) ovr_pulses++;
            if (busy) busy_cycles++;
            if (cmd_err && overrun) both_pulses++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: decode each 8N1 frame on serialOut and compare with the scoreboard.
    initial begin : monitor
        logic [7:0] b;
        logic       stop_b;
        bit         aborted;
        int         st;
        forever begin
            @(negedge clk12MHz);
            if (resetq && serialOut == 1'b0) begin
                st      = cyc;
                aborted = 0;
                b       = '0;
                stop_b  = 1'b0;
                for (int t = 1; t <= CPB/2 - 1 + 9*CPB; t++) begin
                    @(negedge clk12MHz);
                    if (!resetq) begin
                        aborted = 1;
                        break;
                    end
                    if (t >= CPB/2 - 1 + CPB && ((t - (CPB/2 - 1)) % CPB) == 0) begin
                        int s;
                        s = (t - (CPB/2 - 1)) / CPB;
                        if (s <= 8) b[s-1] = serialOut;
                        else stop_b = serialOut;
                    end
                end
                if (!aborted) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        cmp_cnt++;
                        bad_cnt++;
                        $display("FAIL unexpected_byte: got 0x%02h, no byte expected", b);
                    end else begin
                        check("reply_byte", int'(b), int'(exp_q.pop_front()));
                        check("reply_stop_bit", int'(stop_b), 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #(100_000 * 84);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_clks);
        cmd_start_cyc = cyc;
        serialIn = 1'b0;
        repeat (CPB) @(negedge clk12MHz);
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (CPB) @(negedge clk12MHz);
        end
        serialIn = stop_val;
        repeat (stop_clks) @(negedge clk12MHz);
        serialIn = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 4000) begin
            @(negedge clk12MHz);
            n++;
        end
        check({name, "_completes"}, int'(n < 4000), 1);
        repeat (60) @(negedge clk12MHz);
    endtask

    task automatic set_ch(input int ch, input logic [9:0] val);
        ch_values[(ch-1)*10 +: 10] = val;
    endtask

    initial begin : stimulus
        int e0, o0, b0, lat;

        repeat (5) @(negedge clk12MHz);
        check("reset_serialOut", int'(serialOut), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_cmd_err", int'(cmd_err), 0);
        check("reset_overrun", int'(overrun), 0);
        resetq = 1'b1;
        repeat (10) @(negedge clk12MHz);

        // 1: A2 -> 02, C5; busy spans 20 bit times.
        set_ch(2, 10'h2C5);
        start_q.delete();
        b0 = busy_cycles;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hC5);
        send_byte(8'hA2, 1'b1, CPB);
        lat = cmd_start_cyc;
        wait_idle("t1");
        check("t1_busy_cycles", busy_cycles - b0, 20 * CPB);
        check("t1_byte_count", start_q.size(), 2);
        if (start_q.size() > 0) begin
            lat = start_q[0] - lat;
            check("t1_latency_in_window", int'(lat >= 9*CPB + CPB/2 - 1 && lat <= 9*CPB + CPB/2 + 8), 1);
        end

        // 2: unknown command 55.
        start_q.delete();
        e0 = err_pulses;
        b0 = busy_cycles;
        send_byte(8'h55, 1'b1, CPB);
        repeat (200) @(negedge clk12MHz);
        check("t2_cmd_err_pulses", err_pulses - e0, 1);
        check("t2_busy_cycles", busy_cycles - b0, 0);
        check("t2_no_reply", start_q.size(), 0);
        check("t2_line_idle", int'(serialOut), 1);

        // 3: framing error on A1, then A4 -> 03, FF.
        e0 = err_pulses;
        b0 = busy_cycles;
        send_byte(8'hA1, 1'b0, CPB);
        repeat (100) @(negedge clk12MHz);
        check("t3_frame_err_pulses", err_pulses - e0, 1);
        check("t3_no_reply_busy", busy_cycles - b0, 0);
        set_ch(4, 10'h3FF);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hFF);
        send_byte(8'hA4, 1'b1, CPB);
        wait_idle("t3");
        check("t3_cmd_err_total", err_pulses - e0, 1);

        // 4: A1, A3, A2 packed tightly; A2 hits a full pending slot.
        set_ch(1, 10'h100);
        set_ch(3, 10'h1A7);
        start_q.delete();
        o0 = ovr_pulses;
        e0 = err_pulses;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hA7);
        send_byte(8'hA1, 1'b1, 30);
        send_byte(8'hA3, 1'b1, 30);
        send_byte(8'hA2, 1'b1, 30);
        wait_idle("t4");
        check("t4_overrun_pulses", ovr_pulses - o0, 1);
        check("t4_cmd_err_pulses", err_pulses - e0, 0);
        check("t4_byte_count", start_q.size(), 4);
        if (start_q.size() == 4) begin
            check("t4_gap_b0_b1", start_q[1] - start_q[0], 10 * CPB);
            check("t4_gap_resp1_resp2", start_q[2] - start_q[1], 10 * CPB);
            check("t4_gap_b2_b3", start_q[3] - start_q[2], 10 * CPB);
        end

        // 5: ch1 changes mid-reply; reply keeps the snapshot.
        set_ch(1, 10'h100);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        send_byte(8'hA1, 1'b1, CPB);
        check("t5_busy_during_reply", int'(busy), 1);
        set_ch(1, 10'h0FF);
        wait_idle("t5");

        // 6: reset during byte1; only byte0 completes.
        exp_q.push_back(8'h00);
        send_byte(8'hA1, 1'b1, CPB);
        repeat (560) @(negedge clk12MHz);
        check("t6_busy_before_reset", int'(busy), 1);
        resetq = 1'b0;
        #1;
        check("t6_reset_serialOut", int'(serialOut), 1);
        check("t6_reset_busy", int'(busy), 0);
        repeat (5) @(negedge clk12MHz);
        resetq = 1'b1;
        repeat (20) @(negedge clk12MHz);
        check("t6_byte0_seen", exp_q.size(), 0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'hA1, 1'b1, CPB);
        wait_idle("t6");

        check("cmd_err_overrun_exclusive", both_pulses, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
